// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline register with load-use hazard detection,
//               early J/JAL resolution, branch flush and debug event counters.
// Revision    : 1.0
// ============================================================================
module if_id_stage #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic [PC_W-1:0]  PC,
    input  logic             branchFlag,
    input  logic             idexMemRead,
    input  logic [4:0]       idexRt,
    output logic [31:0]      instrOut,
    output logic [PC_W-1:0]  pcOut,
    output logic             validOut,
    output logic             hazardFlag,
    output logic             jumpFlag,
    output logic [PC_W-1:0]  jumpPC,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [PC_W-1:0]  c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_instr;
    logic [PC_W-1:0]  r_pc;
    logic             r_valid;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_isJump;
    logic       w_rsUsed;
    logic       w_rtUsed;
    logic       w_loadUse;

    assign w_op = r_instr[31:26];
    assign w_rs = r_instr[25:21];
    assign w_rt = r_instr[20:16];

    assign w_isJump = (w_op == c_OP_J) || (w_op == c_OP_JAL);
    assign w_rsUsed = !(w_isJump || (w_op == c_OP_LUI));
    assign w_rtUsed = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                      (w_op == c_OP_BNE)   || (w_op == c_OP_SW);

    // $zero never carries a real dependency, so idexRt==0 cannot stall.
    assign w_loadUse = r_valid && idexMemRead && (idexRt != 5'd0) &&
                       ((w_rsUsed && (idexRt == w_rs)) ||
                        (w_rtUsed && (idexRt == w_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= 32'd0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else if (branchFlag) begin
            r_instr <= 32'd0;
            r_pc    <= '0;
            r_valid <= 1'b0;
            if (r_flushCnt != {CNT_W{1'b1}}) begin
                r_flushCnt <= r_flushCnt + c_CNT_ONE;
            end
        end else if (w_loadUse) begin
            if (r_stallCnt != {CNT_W{1'b1}}) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
        end else begin
            r_instr <= Instruction;
            r_pc    <= PC + c_PC_ONE;
            r_valid <= 1'b1;
        end
    end

    assign instrOut   = r_instr;
    assign pcOut      = r_pc;
    assign validOut   = r_valid;
    assign hazardFlag = !w_loadUse;
    assign jumpFlag   = r_valid && w_isJump;
    assign jumpPC     = r_instr[PC_W-1:0];
    assign stallCount = r_stallCnt;
    assign flushCount = r_flushCnt;

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register between instruction fetch and decode.
- Latches the fetched instruction and its return PC (PC+1), and carries a valid bit.
- Detects load-use hazards against the ID/EX stage and drives `hazardFlag` back to fetch.
- Resolves J/JAL early and drives `jumpFlag`/`jumpPC` to fetch; flushes on a taken branch; keeps saturating stall/flush counters for debug.

Parameters:
- PC_W, 10, width of instruction-memory word address.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge (fetch updates PC on falling edge).
- reset  input  1  synchronous, active-high reset.
- Instruction  input  32  instruction word from fetch ROM.
- PC  input  PC_W  address of Instruction.
- branchFlag  input  1  taken branch resolved downstream; flush IF/ID.
- idexMemRead  input  1  instruction in ID/EX is a load.
- idexRt  input  5  destination register of the load in ID/EX.
- instrOut  output  32  latched instruction to decode.
- pcOut  output  PC_W  latched PC+1.
- validOut  output  1  instrOut is a real instruction (0 = bubble).
- hazardFlag  output  1  1 = fetch may advance; 0 = stall (fetch holds PC when low).
- jumpFlag  output  1  valid J/JAL held in IF/ID.
- jumpPC  output  PC_W  jump target, instrOut[PC_W-1:0].
- stallCount  output  CNT_W  cycles with hazardFlag=0, saturating.
- flushCount  output  CNT_W  flush events, saturating.

Behaviour:
- Reset, synchronous, highest priority: `instrOut`=0, `pcOut`=0, `validOut`=0, both counters=0.
  - `hazardFlag` is therefore 1 and `jumpFlag` 0 during and after reset.
  - Reset mid-stall or mid-flush discards all state.
- Operand-use decode, on `instrOut` with op=`instrOut[31:26]`:
  - rs used unless op is J (000010), JAL (000011) or LUI (001111).
  - rt used for op 000000 (R-type), BEQ (000100), BNE (000101), SW (101011).
- `loadUse` (combinational) = `validOut` & `idexMemRead` & (`idexRt`≠0) & ((rs used & `idexRt`==rs) | (rt used & `idexRt`==rt)).
- `hazardFlag` = ~`loadUse`, combinational, no register.
- `jumpFlag` = `validOut` & (op==J | op==JAL), combinational.
  - J/JAL use no registers, so `jumpFlag` and `loadUse` are never both 1.
- `jumpPC` = `instrOut[PC_W-1:0]`, valid only while `jumpFlag`=1.
- Timing: IF/ID captures the instruction at a rising edge. Fetch samples `jumpFlag` at the following falling edge. No wrong-path instruction is fetched after a jump, so there is no jump flush.
- Register update at each rising edge, priority order:
  1. reset.
  2. `branchFlag`=1 → flush: `instrOut`=0, `validOut`=0, `pcOut`=0; `flushCount`+1. Flush overrides stall.
  3. `loadUse`=1 → hold `instrOut`/`pcOut`/`validOut`; `stallCount`+1.
  4. otherwise → `instrOut`=`Instruction`, `pcOut`=`PC`+1 (mod 2^PC_W), `validOut`=1.
- A bubble (`validOut`=0) never raises a hazard or a jump.
- The load-use stall lasts exactly one cycle: the load moves on from ID/EX while IF/ID holds.
- `pcOut` arithmetic wraps: PC=1023 → `pcOut`=0 for PC_W=10.
- Counters saturate at 2^CNT_W−1 and never wrap.
- With branchFlag=1 and loadUse=1 in the same cycle, only `flushCount` increments.
- Latency: `Instruction` to `instrOut` is 1 rising edge.
- `hazardFlag`, `jumpFlag` and `jumpPC` depend only on registered state plus `idexMemRead`/`idexRt`.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then feed PC=0..3 with ADD words → `validOut`=1 from the first post-reset edge; `pcOut`=1,2,3,4; `hazardFlag`=1 throughout; counters 0.
- Load-use stall:
  - IF/ID holds ADD $3,$1,$2 (0x00221820), `idexMemRead`=1, `idexRt`=2 → `hazardFlag`=0 that cycle; `instrOut` held across the edge; `stallCount`=1.
  - Next cycle, `idexMemRead`=0 → `hazardFlag`=1; next instruction latched.
- Zero-register and unused-rt cases:
  - `idexRt`=0 with rs=0 → no stall.
  - ADDI $5,$4,7 (op 001000) with `idexRt`=5 matching its rt → no stall, since rt is not used.
- Jump: latch J with target 0x155 (0x08000155) → `jumpFlag`=1, `jumpPC`=0x155 in the same cycle; next latched PC from fetch = 0x155, `pcOut`=0x156.
- Branch flush over stall: `branchFlag`=1 while `loadUse`=1 → after the edge `validOut`=0, `instrOut`=0, `flushCount`=1, `stallCount` unchanged, `hazardFlag`=1.
- Wrap and saturation: PC=1023 → `pcOut`=0. Force 65540 consecutive stall cycles → `stallCount`=65535.
